collision_resolver: RTL and testbench
=====================================

Name: collision_resolver

Overview:
- Sequential response side of the axis-aligned box collision check: takes two center-referenced boxes, decides whether they overlap and computes the corrected position of the first object.
- Pushes the first object out along the axis of minimum penetration, clamped to screen bounds.
- Sits between the object position registers and the physics/update logic. Accepts one request per start pulse and returns registered results with a one-cycle done pulse.

Parameters:
- MAX_X, 639, largest legal x coordinate; corrected x is clamped to [0, MAX_X].
- MAX_Y, 479, largest legal y coordinate; corrected y is clamped to [0, MAX_Y].

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; accepted only when busy=0
- f_x, f_y  input  10 each  first object center
- f_w, f_h  input  10 each  first object width/height
- s_x, s_y  input  10 each  second object center
- s_w, s_h  input  10 each  second object width/height
- busy  output  1  request in progress
- done  output  1  one-cycle pulse; result outputs valid from this cycle
- hit  output  1  boxes overlap
- axis  output  1  push axis: 0=X, 1=Y (0 when hit=0)
- depth  output  11  penetration depth along the push axis (0 when hit=0)
- res_x, res_y  output  10 each  corrected first-object center

Behaviour:
- Reset: one clock, active-high, synchronous. Clears busy, done, hit, axis, depth, res_x and res_y to 0, and puts the FSM in IDLE. Reset mid-operation aborts the request with no done pulse.
- FSM states: IDLE -> CALC -> PEN -> RESOLVE -> IDLE.
- IDLE: at an edge with start=1, all 8 operands are latched, busy goes to 1, state goes to CALC. Operand changes after that edge have no effect.
- CALC: compute half extents f_hw=f_w>>1, s_hw=s_w>>1, f_hh=f_h>>1, s_hh=s_h>>1 (floor). Compute sum_x=f_hw+s_hw and sum_y=f_hh+s_hh (11-bit). Compute dx=|f_x-s_x| and dy=|f_y-s_y| (11-bit, no wrap). Register the sign flags fx_ge = (f_x>=s_x) and fy_ge = (f_y>=s_y).
- PEN: pen_x = sum_x-dx if dx<sum_x, else 0; pen_y likewise. Overlap is strict: touching edges (dx==sum_x) is not a hit. hit_n = (pen_x!=0) && (pen_y!=0).
- RESOLVE: registers all outputs, sets done=1 and busy=0, returns to IDLE.
  - If hit_n=0: hit=0, axis=0, depth=0, res = latched (f_x, f_y).
  - Else if pen_x<=pen_y (tie goes to X): axis=0, depth=pen_x, res_y=f_y, res_x = f_x+pen_x if fx_ge, else f_x-pen_x.
  - Else: axis=1, depth=pen_y, res_x=f_x, res_y = f_y+pen_y if fy_ge, else f_y-pen_y.
  - Arithmetic is signed 12-bit. A result below 0 clamps to 0; a result above MAX clamps to MAX.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+3 (4 clocks). busy=1 in the cycles after edges k..k+2.
- done lasts exactly one cycle. hit, axis, depth, res_x and res_y hold their values until the next RESOLVE or reset.
- start=1 while busy=1 is ignored and not queued.
- start=1 in the done cycle (busy=0) is accepted, giving back-to-back throughput of one request per 4 clocks.
- Zero width/height: half extent is 0, so an overlap on that axis requires the other box's half extent > dx.

Test Plan:
1. X push: f=(100,100,w20,h20), s=(115,100,20,20), start pulse. Required: done exactly 4 clocks later; hit=1, axis=0, depth=5, res=(95,100); busy high for the 3 intermediate cycles.
2. Touching, no hit: f=(100,100,20,20), s=(120,100,20,20). Required: hit=0, axis=0, depth=0, res=(100,100).
3. Y push: f=(200,210,40,20), s=(200,200,40,20). pen_x=40, pen_y=10. Required: hit=1, axis=1, depth=10, res=(200,220).
4. Tie and lower clamp:
   - f=(50,50,20,20), s=(60,60,20,20). Required: axis=0, depth=10, res=(40,50).
   - f=(3,100,20,20), s=(10,100,20,20). Required: depth=13, res_x=0.
   - f=(635,100,20,20), s=(630,100,20,20). Required: res_x clamped to 639.
5. Handshake: start again one cycle after acceptance with different operands. Required: ignored; the result matches the first request. start held high through the done cycle is accepted; the second done comes 4 clocks after the first.
6. Reset mid-op: assert reset during PEN. Required: next cycle busy=0, done=0, all outputs 0, no done pulse; a fresh start afterward completes normally.

Source files
------------

// File: rtl/collision_resolver.sv
// collision_resolver: AABB overlap test with minimum-penetration push-out of the first box, clamped to screen (start/busy/done handshake, 4-cycle latency)
module collision_resolver #(
  parameter int MAX_X = 639,
  parameter int MAX_Y = 479
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  f_x,
  input  logic [9:0]  f_y,
  input  logic [9:0]  f_w,
  input  logic [9:0]  f_h,
  input  logic [9:0]  s_x,
  input  logic [9:0]  s_y,
  input  logic [9:0]  s_w,
  input  logic [9:0]  s_h,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic        axis,
  output logic [10:0] depth,
  output logic [9:0]  res_x,
  output logic [9:0]  res_y
);
  typedef enum logic [1:0] {IDLE, CALC, PEN, RESOLVE} state_t;
  localparam logic [9:0] max_x = 10'(MAX_X);
  localparam logic [9:0] max_y = 10'(MAX_Y);
  state_t st;
  logic [9:0] fx, fy, fw, fh, sx, sy, sw, sh;
  logic [10:0] sum_x, sum_y, dx, dy, pen_x, pen_y;
  logic fx_ge, fy_ge, hit_n, push_y;
  logic signed [11:0] px, py;
  function automatic logic [9:0] clamp(input logic signed [11:0] v, input logic [9:0] mx);
    return v[11] ? 10'd0 : (v[10:0] > {1'b0, mx}) ? mx : v[9:0];
  endfunction
  always_comb begin
    px = fx_ge ? {2'b0, fx} + {1'b0, pen_x} : {2'b0, fx} - {1'b0, pen_x};
    py = fy_ge ? {2'b0, fy} + {1'b0, pen_y} : {2'b0, fy} - {1'b0, pen_y};
    push_y = pen_x > pen_y;
  end
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      hit <= 1'b0;
      axis <= 1'b0;
      depth <= '0;
      res_x <= '0;
      res_y <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          {fx, fy, fw, fh} <= {f_x, f_y, f_w, f_h};
          {sx, sy, sw, sh} <= {s_x, s_y, s_w, s_h};
          busy <= 1'b1;
          st <= CALC;
        end
        CALC: begin
          sum_x <= {2'b0, fw[9:1]} + {2'b0, sw[9:1]};
          sum_y <= {2'b0, fh[9:1]} + {2'b0, sh[9:1]};
          dx <= fx >= sx ? {1'b0, fx} - {1'b0, sx} : {1'b0, sx} - {1'b0, fx};
          dy <= fy >= sy ? {1'b0, fy} - {1'b0, sy} : {1'b0, sy} - {1'b0, fy};
          fx_ge <= fx >= sx;
          fy_ge <= fy >= sy;
          st <= PEN;
        end
        PEN: begin
          pen_x <= dx < sum_x ? sum_x - dx : '0;
          pen_y <= dy < sum_y ? sum_y - dy : '0;
          hit_n <= dx < sum_x && dy < sum_y;
          st <= RESOLVE;
        end
        RESOLVE: begin
          busy <= 1'b0;
          done <= 1'b1;
          hit <= hit_n;
          axis <= hit_n && push_y;
          depth <= !hit_n ? '0 : push_y ? pen_y : pen_x;
          res_x <= hit_n && !push_y ? clamp(px, max_x) : fx;
          res_y <= hit_n && push_y ? clamp(py, max_y) : fy;
          st <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_collision_resolver.sv
// tb_collision_resolver: directed self-checking bench for collision_resolver
module tb_collision_resolver;
  logic clk = 0, reset = 1, start = 0;
  logic [9:0] f_x = 0, f_y = 0, f_w = 0, f_h = 0, s_x = 0, s_y = 0, s_w = 0, s_h = 0;
  logic busy, done, hit, axis;
  logic [10:0] depth;
  logic [9:0] res_x, res_y;
  int checks = 0, failures = 0, n, bsy, dn;
  collision_resolver dut (
    .clk(clk), .reset(reset), .start(start),
    .f_x(f_x), .f_y(f_y), .f_w(f_w), .f_h(f_h),
    .s_x(s_x), .s_y(s_y), .s_w(s_w), .s_h(s_h),
    .busy(busy), .done(done), .hit(hit), .axis(axis),
    .depth(depth), .res_x(res_x), .res_y(res_y)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic set_ops(input logic [9:0] a, b, c, d, e, f, g, h);
    {f_x, f_y, f_w, f_h, s_x, s_y, s_w, s_h} = {a, b, c, d, e, f, g, h};
  endtask
  task automatic req(input logic [9:0] a, b, c, d, e, f, g, h);
    set_ops(a, b, c, d, e, f, g, h);
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_done(output int cnt);
    cnt = 0;
    bsy = 0;
    while (!done && cnt < 10) begin
      if (busy) bsy++;
      @(posedge clk);
      #1 cnt++;
    end
  endtask
  task automatic res(input string tag, input logic h, a, input int d, x, y);
    chk({tag, ".hit"}, 32'(hit), 32'(h));
    chk({tag, ".axis"}, 32'(axis), 32'(a));
    chk({tag, ".depth"}, 32'(depth), d);
    chk({tag, ".res_x"}, 32'(res_x), x);
    chk({tag, ".res_y"}, 32'(res_y), y);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    res("rst", 0, 0, 0, 0, 0);
    req(100, 100, 20, 20, 115, 100, 20, 20);
    wait_done(n);
    chk("t1.latency", n, 3);
    chk("t1.busy_cycles", bsy, 3);
    chk("t1.busy_at_done", 32'(busy), 0);
    res("t1", 1, 0, 5, 95, 100);
    @(posedge clk);
    #1 chk("t1.done_pulse", 32'(done), 0);
    res("t1.hold", 1, 0, 5, 95, 100);
    req(100, 100, 20, 20, 120, 100, 20, 20);
    wait_done(n);
    chk("t2.latency", n, 3);
    res("t2", 0, 0, 0, 100, 100);
    req(200, 210, 40, 20, 200, 200, 40, 20);
    wait_done(n);
    res("t3", 1, 1, 10, 200, 220);
    req(50, 50, 20, 20, 60, 60, 20, 20);
    wait_done(n);
    res("t4a", 1, 0, 10, 40, 50);
    req(3, 100, 20, 20, 10, 100, 20, 20);
    wait_done(n);
    res("t4b", 1, 0, 13, 0, 100);
    req(635, 100, 20, 20, 630, 100, 20, 20);
    wait_done(n);
    res("t4c", 1, 0, 15, 639, 100);
    req(100, 100, 20, 20, 115, 100, 20, 20);
    set_ops(200, 210, 40, 20, 200, 200, 40, 20);
    start = 1;
    wait_done(n);
    chk("t5.latency", n, 3);
    res("t5a", 1, 0, 5, 95, 100);
    @(posedge clk);
    #1 start = 0;
    chk("t5.accept_busy", 32'(busy), 1);
    wait_done(n);
    chk("t5.b2b_gap", n + 1, 4);
    res("t5b", 1, 1, 10, 200, 220);
    req(100, 100, 20, 20, 115, 100, 20, 20);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    chk("t6.busy", 32'(busy), 0);
    chk("t6.done", 32'(done), 0);
    res("t6", 0, 0, 0, 0, 0);
    dn = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (done) dn++;
    end
    chk("t6.no_done", dn, 0);
    req(200, 210, 40, 20, 200, 200, 40, 20);
    wait_done(n);
    chk("t6.latency", n, 3);
    res("t6b", 1, 1, 10, 200, 220);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
